// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router output channel.
// Each entry holds a data word plus its start-of-packet tag. The read side
// decodes the header length to find the end of each packet and pulses
// pkt_done alongside the final (parity) word.
module router_pkt_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              sop_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic              pkt_done,
    output logic              ovf_err,
    output logic              udf_err
);

    localparam int LEN_W = DATA_W - 2;
    // One extra bit so that a maximum-length header plus its parity word fits.
    localparam int REM_W = LEN_W + 1;
    localparam logic [ADDR_W:0] AF_CNT  = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
    localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

    logic [DATA_W:0]    mem [DEPTH];
    logic [ADDR_W:0]    wr_ptr;
    logic [ADDR_W:0]    rd_ptr;
    logic [REM_W-1:0]   remaining;
    logic               flush;
    logic               wr_acc;
    logic               rd_acc;
    logic [DATA_W:0]    rd_entry;
    logic [LEN_W-1:0]   hdr_len;

    // Status is derived purely from the registered pointers; the extra MSB
    // distinguishes a full FIFO from an empty one when the indices match.
    assign flush       = !resetn || soft_reset;
    assign count       = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                         (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign almost_full = (count >= AF_CNT);
    assign wr_acc      = write_enb && !full;
    assign rd_acc      = read_enb && !empty;
    assign rd_entry    = mem[rd_ptr[ADDR_W-1:0]];
    assign hdr_len     = rd_entry[DATA_W-1:2];

    // Storage array; contents are left untouched by a flush.
    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {sop_in, data_in};
        end
    end

    // Write/read pointers and the sticky overflow/underflow flags.
    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (write_enb && full) begin
                ovf_err <= 1'b1;
            end
            if (read_enb && empty) begin
                udf_err <= 1'b1;
            end
        end
    end

    // Registered read data plus the packet-boundary down-counter; a new header
    // always reloads the counter, silently abandoning any unfinished packet.
    always_ff @(posedge clock) begin
        if (flush) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            pkt_done   <= 1'b0;
            remaining  <= '0;
        end else begin
            data_valid <= rd_acc;
            pkt_done   <= 1'b0;
            if (rd_acc) begin
                data_out <= rd_entry[DATA_W-1:0];
                if (rd_entry[DATA_W]) begin
                    remaining <= {1'b0, hdr_len} + REM_ONE;
                end else if (remaining != '0) begin
                    remaining <= remaining - REM_ONE;
                    pkt_done  <= (remaining == REM_ONE);
                end
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Self-checking bench for router_pkt_fifo: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_router_pkt_fifo;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              soft_reset = 1'b0;
    logic              write_enb = 1'b0;
    logic              sop_in = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              read_enb = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic [ADDR_W:0]   count;
    logic              pkt_done;
    logic              ovf_err;
    logic              udf_err;

    int checks = 0;
    int failures = 0;
    int pd_seen = 0;

    // Reference model: queue of {sop, data} and packet word countdown.
    logic [DATA_W:0] q[$];
    int              m_rem = 0;
    logic [DATA_W-1:0] m_dout = '0;
    logic            m_dv = 0;
    logic            m_pd = 0;
    logic            m_ovf = 0;
    logic            m_udf = 0;

    router_pkt_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .sop_in     (sop_in),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .data_valid (data_valid),
        .empty      (empty),
        .full       (full),
        .almost_full(almost_full),
        .count      (count),
        .pkt_done   (pkt_done),
        .ovf_err    (ovf_err),
        .udf_err    (udf_err)
    );

    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [DATA_W:0] e;
        bit wacc, racc;
        if (!resetn || soft_reset) begin
            q.delete();
            m_rem = 0; m_dout = '0; m_dv = 0; m_pd = 0; m_ovf = 0; m_udf = 0;
        end else begin
            wacc = write_enb && (q.size() < DEPTH);
            racc = read_enb && (q.size() > 0);
            if (write_enb && !wacc) m_ovf = 1;
            if (read_enb && !racc) m_udf = 1;
            m_dv = racc;
            m_pd = 0;
            if (racc) begin
                e = q.pop_front();
                m_dout = e[DATA_W-1:0];
                if (e[DATA_W]) begin
                    m_rem = int'(e[DATA_W-1:2]) + 1;
                end else if (m_rem > 0) begin
                    m_rem = m_rem - 1;
                    if (m_rem == 0) m_pd = 1;
                end
            end
            if (wacc) q.push_back({sop_in, data_in});
        end
    endtask

    task automatic step(input logic rn, input logic sr, input logic we, input logic sp,
                        input logic [DATA_W-1:0] d, input logic re);
        resetn = rn; soft_reset = sr; write_enb = we; sop_in = sp; data_in = d; read_enb = re;
        @(posedge clock);
        model_edge();
        #1;
        if (pkt_done) pd_seen++;
        chk_eq("data_out", data_out, m_dout);
        chk_eq("data_valid", data_valid, m_dv);
        chk_eq("pkt_done", pkt_done, m_pd);
        chk_eq("count", count, q.size());
        chk_eq("empty", empty, q.size() == 0);
        chk_eq("full", full, q.size() == DEPTH);
        chk_eq("almost_full", almost_full, q.size() >= DEPTH - 2);
        chk_eq("ovf_err", ovf_err, m_ovf);
        chk_eq("udf_err", udf_err, m_udf);
    endtask

    task automatic wr(input logic sp, input logic [DATA_W-1:0] d);
        step(1, 0, 1, sp, d, 0);
    endtask

    task automatic rd();
        step(1, 0, 0, 0, '0, 1);
    endtask

    task automatic flush_soft();
        step(1, 1, 0, 0, '0, 0);
    endtask

    initial begin
        int pd0;
        // Reset
        step(0, 0, 0, 0, '0, 0);
        chk_eq("rst_empty", empty, 1);
        chk_eq("rst_count", count, 0);
        chk_eq("rst_data_out", data_out, 0);
        chk_eq("rst_flags", {ovf_err, udf_err, pkt_done, data_valid, full, almost_full}, 0);

        // Single packet: header len=3, three payload words, parity
        pd0 = pd_seen;
        wr(1, 8'h0C);
        for (int i = 0; i < 3; i++) wr(0, 8'($urandom));
        wr(0, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            rd();
            chk_eq("pkt_no_early_done", pkt_done, 0);
        end
        rd();
        chk_eq("pkt_parity_word", data_out, 8'hA5);
        chk_eq("pkt_done_last", pkt_done, 1);
        chk_eq("pkt_done_total", pd_seen - pd0, 1);

        // Fill to full, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) begin
            wr(0, 8'(i * 7 + 3));
            if (i == DEPTH - 4) chk_eq("af_below", almost_full, 0);
            if (i == DEPTH - 3) chk_eq("af_at_14", almost_full, 1);
        end
        chk_eq("fill_full", full, 1);
        chk_eq("fill_count", count, 16);
        wr(0, 8'hFF);
        chk_eq("ovf_set", ovf_err, 1);
        chk_eq("ovf_count", count, 16);
        for (int i = 0; i < DEPTH; i++) begin
            rd();
            chk_eq("drain_word", data_out, 8'(i * 7 + 3));
        end
        chk_eq("drain_empty", empty, 1);

        // Wrap-around with concurrent read and write
        flush_soft();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 10; i++) wr(0, 8'($urandom));
            for (int i = 0; i < 10; i++) step(1, 0, 1, 0, 8'($urandom), 1);
            for (int i = 0; i < 10; i++) rd();
        end
        chk_eq("wrap_empty", empty, 1);

        // Underflow and simultaneous operations at the boundaries
        flush_soft();
        rd();
        chk_eq("udf_set", udf_err, 1);
        chk_eq("udf_no_valid", data_valid, 0);
        step(1, 0, 1, 0, 8'h3C, 1);
        chk_eq("rdwr_empty_count", count, 1);
        for (int i = 0; i < DEPTH - 1; i++) wr(0, 8'($urandom));
        step(1, 0, 1, 0, 8'h77, 1);
        chk_eq("rdwr_full_count", count, 15);
        step(1, 0, 1, 0, 8'h78, 1);
        chk_eq("rdwr_notfull_count", count, 15);

        // Mid-packet flush, orphan word, then a fresh packet
        flush_soft();
        chk_eq("flush_clears_udf", udf_err, 0);
        wr(1, 8'h0C);
        for (int i = 0; i < 4; i++) wr(0, 8'($urandom));
        rd(); rd();
        pd0 = pd_seen;
        flush_soft();
        chk_eq("mid_flush_empty", empty, 1);
        chk_eq("mid_flush_count", count, 0);
        wr(0, 8'h11);
        rd();
        chk_eq("orphan_no_done", pkt_done, 0);
        wr(1, 8'h04);
        wr(0, 8'h22);
        wr(0, 8'h33);
        rd(); rd(); rd();
        chk_eq("new_pkt_done", pkt_done, 1);
        chk_eq("mid_flush_done_total", pd_seen - pd0, 1);

        // Randomized traffic in write-heavy and read-heavy phases
        for (int ph = 0; ph < 12; ph++) begin
            int wp = (ph % 2 == 0) ? 75 : 30;
            int rp = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 250; i++) begin
                logic rn, sr, we, sp, re;
                logic [DATA_W-1:0] d;
                rn = ($urandom_range(0, 399) != 0);
                sr = ($urandom_range(0, 149) == 0);
                we = ($urandom_range(0, 99) < wp);
                re = ($urandom_range(0, 99) < rp);
                sp = ($urandom_range(0, 3) == 0);
                d  = sp ? {3'b000, 3'($urandom), 2'($urandom)} : 8'($urandom);
                step(rn, sr, we, sp, d, re);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
